// File: rtl/updi_instruction_sequencer.sv
// UPDI instruction sequencer: latches one request and streams SYNCH, opcode and
// data bytes into the TX FIFO, optionally pausing for an RX ACK after data bytes.
module updi_instruction_sequencer #(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int ACK_TIMEOUT    = 4096,
  parameter int TIMEOUT_BITS   = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  output logic                                 o_ready,
  input  logic                                 i_send_synch,
  input  logic [7:0]                           i_opcode,
  input  logic [MAX_DATA_SIZE-1:0][7:0]        i_data,
  input  logic [DATA_ADDR_BITS:0]              i_data_len,
  input  logic [MAX_DATA_SIZE-1:0]             i_wait_ack_after,
  input  logic                                 i_ack_received,
  output logic                                 o_waiting_for_ack,
  input  logic                                 i_abort,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [1:0]                           o_err_code,
  output logic [DATA_ADDR_BITS+1:0]            o_bytes_sent,
  output logic [7:0]                           o_fifo_data,
  output logic                                 o_fifo_wr_en,
  input  logic                                 i_fifo_full
);

  localparam int LW    = DATA_ADDR_BITS + 1;
  localparam int BW    = DATA_ADDR_BITS + 2;
  localparam int CNT_W = (TIMEOUT_BITS < 1) ? 1 : TIMEOUT_BITS;
  localparam logic [LW-1:0]    LEN_MAX   = LW'(MAX_DATA_SIZE);
  localparam logic [BW-1:0]    BYTES_MAX = BW'(MAX_DATA_SIZE + 2);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SYNCH = 3'd1,
    S_WR_OPCODE= 3'd2,
    S_WR_DATA  = 3'd3,
    S_WAIT_ACK = 3'd4
  } t_state;

  t_state                          r_state, w_state;
  logic [7:0]                      r_opcode, w_opcode;
  logic [MAX_DATA_SIZE-1:0][7:0]   r_data, w_data;
  logic [LW-1:0]                   r_len, w_len;
  logic [MAX_DATA_SIZE-1:0]        r_mask, w_mask;
  logic [DATA_ADDR_BITS-1:0]       r_idx, w_idx;
  logic [CNT_W-1:0]                r_tcnt, w_tcnt;
  logic [BW-1:0]                   r_bytes, w_bytes;
  logic [1:0]                      r_err_code, w_err_code;
  logic [7:0]                      r_fifo_data, w_fifo_data;
  logic                            r_fifo_wr_en, w_fifo_wr_en;
  logic                            r_done, w_done;
  logic                            r_error, w_error;
  logic                            r_ready, r_waiting;
  logic [7:0]                      w_cur_byte;
  logic                            w_last;

  function automatic logic [BW-1:0] f_sat_inc(input logic [BW-1:0] v);
    f_sat_inc = (v == BYTES_MAX) ? v : v + BW'(1);
  endfunction

  // Next-state and next-output logic; abort outranks every other event
  always_comb begin
    w_state      = r_state;
    w_opcode     = r_opcode;
    w_data       = r_data;
    w_len        = r_len;
    w_mask       = r_mask;
    w_idx        = r_idx;
    w_tcnt       = r_tcnt;
    w_bytes      = r_bytes;
    w_err_code   = r_err_code;
    w_fifo_data  = r_fifo_data;
    w_fifo_wr_en = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    w_last       = ({1'b0, r_idx} == (r_len - LW'(1)));
    case (r_state)
      S_WR_SYNCH:  w_cur_byte = 8'h55;
      S_WR_OPCODE: w_cur_byte = r_opcode;
      default:     w_cur_byte = r_data[r_idx];
    endcase

    if ((r_state != S_IDLE) && i_abort) begin
      w_state    = S_IDLE;
      w_error    = 1'b1;
      w_err_code = 2'b10;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ready && i_start && !i_abort) begin
            w_opcode   = i_opcode;
            w_data     = i_data;
            w_len      = (i_data_len > LEN_MAX) ? LEN_MAX : i_data_len;
            w_mask     = i_wait_ack_after;
            w_bytes    = '0;
            w_err_code = 2'b00;
            w_state    = i_send_synch ? S_WR_SYNCH : S_WR_OPCODE;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_WR_SYNCH, S_WR_OPCODE, S_WR_DATA: begin
          if (!i_fifo_full) begin
            w_fifo_wr_en = 1'b1;
            w_fifo_data  = w_cur_byte;
            w_bytes      = f_sat_inc(r_bytes);
            case (r_state)
              S_WR_SYNCH: w_state = S_WR_OPCODE;
              S_WR_OPCODE: begin
                if (r_len != LW'(0)) begin
                  w_state = S_WR_DATA;
                  w_idx   = '0;
                end else begin
                  w_state = S_IDLE;
                  w_done  = 1'b1;
                end
              end
              default: begin
                if (r_mask[r_idx]) begin
                  w_state = S_WAIT_ACK;
                  w_tcnt  = '0;
                end else if (w_last) begin
                  w_state = S_IDLE;
                  w_done  = 1'b1;
                end else begin
                  w_idx = r_idx + DATA_ADDR_BITS'(1);
                end
              end
            endcase
          end else begin
            w_state = r_state;
          end
        end
        S_WAIT_ACK: begin
          if (i_ack_received) begin
            if (w_last) begin
              w_state = S_IDLE;
              w_done  = 1'b1;
            end else begin
              w_state = S_WR_DATA;
              w_idx   = r_idx + DATA_ADDR_BITS'(1);
            end
          end else if ((ACK_TIMEOUT != 0) && (r_tcnt == TO_LAST)) begin
            w_state    = S_IDLE;
            w_error    = 1'b1;
            w_err_code = 2'b01;
          end else begin
            w_tcnt = r_tcnt + CNT_W'(1);
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and output registers; ready rises on the first edge after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_opcode     <= 8'h00;
      r_data       <= '0;
      r_len        <= '0;
      r_mask       <= '0;
      r_idx        <= '0;
      r_tcnt       <= '0;
      r_bytes      <= '0;
      r_err_code   <= 2'b00;
      r_fifo_data  <= 8'h00;
      r_fifo_wr_en <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_ready      <= 1'b0;
      r_waiting    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_opcode     <= w_opcode;
      r_data       <= w_data;
      r_len        <= w_len;
      r_mask       <= w_mask;
      r_idx        <= w_idx;
      r_tcnt       <= w_tcnt;
      r_bytes      <= w_bytes;
      r_err_code   <= w_err_code;
      r_fifo_data  <= w_fifo_data;
      r_fifo_wr_en <= w_fifo_wr_en;
      r_done       <= w_done;
      r_error      <= w_error;
      r_ready      <= (w_state == S_IDLE);
      r_waiting    <= (w_state == S_WAIT_ACK);
    end
  end

  assign o_ready           = r_ready;
  assign o_waiting_for_ack = r_waiting;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_err_code        = r_err_code;
  assign o_bytes_sent      = r_bytes;
  assign o_fifo_data       = r_fifo_data;
  assign o_fifo_wr_en      = r_fifo_wr_en;

endmodule

// File: tb/tb_updi_instruction_sequencer.sv
// Bench for updi_instruction_sequencer: queue-based model of the expected byte
// stream and completion events, checked every cycle, plus directed literal checks.
module tb_updi_instruction_sequencer;
  localparam int MAXD   = 16;
  localparam int ACK_TO = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, send_synch = 1'b0, ack = 1'b0, abort = 1'b0, full = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic [MAXD-1:0][7:0] data = '0;
  logic [4:0] data_len = 5'd0;
  logic [MAXD-1:0] mask = '0;
  logic ready, waiting, done, error, wr_en;
  logic [1:0] err_code;
  logic [5:0] bytes_sent;
  logic [7:0] fifo_data;

  int n_tests = 0, n_fail = 0;

  updi_instruction_sequencer #(.MAX_DATA_SIZE(MAXD), .ACK_TIMEOUT(ACK_TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_ready(ready),
    .i_send_synch(send_synch), .i_opcode(opcode), .i_data(data),
    .i_data_len(data_len), .i_wait_ack_after(mask), .i_ack_received(ack),
    .o_waiting_for_ack(waiting), .i_abort(abort), .o_done(done), .o_error(error),
    .o_err_code(err_code), .o_bytes_sent(bytes_sent), .o_fifo_data(fifo_data),
    .o_fifo_wr_en(wr_en), .i_fifo_full(full));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state: remaining bytes as {wait_after, byte}
  logic [8:0] exp_q[$];
  logic [7:0] got[$];
  bit m_busy = 0, m_ready = 0, m_wait = 0, m_done, m_error, m_wr;
  int m_wcyc = 0, m_bytes = 0, wait_cnt = 0;
  logic [1:0] m_err = 2'b00;
  logic [7:0] m_byte = 8'h00;

  // Compare process: advance the model one clock and check every output
  initial begin
    logic [8:0] ent;
    int n;
    forever begin
      @(posedge clk); #1;
      m_wr = 0; m_done = 0; m_error = 0;
      if (rst) begin
        m_busy = 0; m_wait = 0; m_err = 2'b00; m_bytes = 0; m_byte = 8'h00;
        exp_q.delete();
      end else if (!m_busy) begin
        if (m_ready && start && !abort) begin
          n = (data_len > MAXD) ? MAXD : int'(data_len);
          exp_q.delete();
          if (send_synch) exp_q.push_back({1'b0, 8'h55});
          exp_q.push_back({1'b0, opcode});
          for (int i = 0; i < n; i++) exp_q.push_back({mask[i], data[i]});
          m_busy = 1; m_bytes = 0; m_err = 2'b00; wait_cnt = 0;
        end
      end else if (abort) begin
        m_busy = 0; m_wait = 0; m_error = 1; m_err = 2'b10; exp_q.delete();
      end else if (m_wait) begin
        if (ack) begin
          m_wait = 0;
          if (exp_q.size() == 0) begin m_busy = 0; m_done = 1; end
        end else begin
          m_wcyc++;
          if (m_wcyc == ACK_TO) begin
            m_wait = 0; m_busy = 0; m_error = 1; m_err = 2'b01; exp_q.delete();
          end
        end
      end else if (!full) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL model: busy with no bytes left");
          m_busy = 0;
        end else begin
          ent = exp_q.pop_front();
          m_wr = 1; m_byte = ent[7:0];
          if (m_bytes < MAXD + 2) m_bytes++;
          if (ent[8]) begin m_wait = 1; m_wcyc = 0; end
          else if (exp_q.size() == 0) begin m_busy = 0; m_done = 1; end
        end
      end
      m_ready = !rst && !m_busy;
      if (wr_en) got.push_back(fifo_data);
      if (waiting) wait_cnt++;
      chk("wr_en", wr_en, m_wr);
      if (m_wr || rst) chk("fifo_data", fifo_data, m_byte);
      chk("done", done, m_done);
      chk("error", error, m_error);
      chk("err_code", err_code, m_err);
      chk("bytes_sent", bytes_sent, m_bytes);
      chk("ready", ready, m_ready);
      chk("waiting", waiting, m_wait);
    end
  end

  task automatic issue(input logic sy, input logic [7:0] op, input logic [4:0] len,
                       input logic [MAXD-1:0] mk);
    @(negedge clk);
    got.delete();
    send_synch = sy; opcode = op; data_len = len; mask = mk; start = 1'b1;
    @(negedge clk);
    start = 1'b0; send_synch = 1'b0; opcode = 8'hEE; mask = '0;
  endtask

  task automatic wait_end(input string nm);
    int k;
    k = 0;
    while (!(done || error) && k < 200) begin @(negedge clk); k++; end
    n_tests++;
    if (!(done || error)) begin
      n_fail++;
      $display("FAIL %s: no done/error within bound", nm);
    end
  endtask

  task automatic wait_waiting(input string nm);
    int k;
    k = 0;
    while (!waiting && k < 50) begin @(negedge clk); k++; end
    n_tests++;
    if (!waiting) begin
      n_fail++;
      $display("FAIL %s: never entered ACK wait", nm);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst ready", ready, 1'b0);
    chk("rst fifo_data", fifo_data, 8'h00);
    rst = 1'b0;

    // 1: synch + opcode, no data
    issue(1'b1, 8'h04, 5'd0, '0);
    wait_end("t1");
    chk("t1 done", done, 1'b1);
    chk("t1 bytes", bytes_sent, 6'd2);
    chk("t1 err", err_code, 2'b00);
    chk("t1 n", got.size(), 2);
    if (got.size() == 2) begin
      chk("t1 b0", got[0], 8'h55);
      chk("t1 b1", got[1], 8'h04);
    end

    // start together with abort in IDLE is ignored
    @(negedge clk); opcode = 8'h77; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("idle abort ready", ready, 1'b1);
    repeat (2) @(negedge clk);
    chk("idle abort wr", wr_en, 1'b0);

    // 2: three data bytes back-to-back
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
    issue(1'b0, 8'h64, 5'd3, '0);
    wait_end("t2");
    chk("t2 bytes", bytes_sent, 6'd4);
    chk("t2 n", got.size(), 4);
    if (got.size() == 4) begin
      chk("t2 b0", got[0], 8'h64);
      chk("t2 b3", got[3], 8'h33);
    end

    // 3: ACK wait after 0x22, ACK after 5 waiting cycles
    issue(1'b0, 8'h64, 5'd3, 16'b010);
    wait_waiting("t3 wait");
    repeat (4) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    wait_end("t3");
    chk("t3 done", done, 1'b1);
    chk("t3 waitcnt", wait_cnt, 5);
    chk("t3 n", got.size(), 4);

    // 4: ACK timeout after the first data byte
    data[0] = 8'h11; data[1] = 8'h22;
    issue(1'b0, 8'h44, 5'd2, 16'b001);
    wait_end("t4");
    chk("t4 error", error, 1'b1);
    chk("t4 err", err_code, 2'b01);
    chk("t4 ready", ready, 1'b1);
    chk("t4 waitcnt", wait_cnt, 8);
    chk("t4 n", got.size(), 2);

    // 5: backpressure during data, then abort
    data[0] = 8'hAA; data[1] = 8'hBB; data[2] = 8'hCC; data[3] = 8'hDD;
    issue(1'b0, 8'h20, 5'd4, '0);
    @(negedge clk); full = 1'b1;
    repeat (3) @(negedge clk);
    full = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5 error", error, 1'b1);
    chk("t5 err", err_code, 2'b10);
    chk("t5 wr", wr_en, 1'b0);
    chk("t5 bytes", bytes_sent, 6'd2);
    chk("t5 n", got.size(), 2);

    // 6: reset while waiting for ACK, then an over-long request is clamped
    issue(1'b1, 8'h30, 5'd2, 16'b001);
    wait_waiting("t6 wait");
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst ready", ready, 1'b0);
    chk("t6 rst waiting", waiting, 1'b0);
    chk("t6 rst bytes", bytes_sent, 6'd0);
    rst = 1'b0;
    for (int i = 0; i < MAXD; i++) data[i] = 8'(i * 3 + 1);
    issue(1'b0, 8'h5A, 5'd20, '0);
    wait_end("t6");
    chk("t6 done", done, 1'b1);
    chk("t6 bytes", bytes_sent, 6'd17);
    chk("t6 n", got.size(), 17);
    if (got.size() == 17) chk("t6 last", got[16], 8'd46);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
